padded_msg_reader: RTL and testbench
====================================

Name: padded_msg_reader

Overview:
- Reader side of the SHA-256 padded-message buffer.
- Accepts a 1024-bit padded block-header message (80-byte header, separator bit, zero fill, 64-bit length), checks that the padding is well formed, then streams the message MSB-first as 32 words of 32 bits with a valid/ready handshake.
- Sits between the header padder and the SHA-256 compression/message-schedule core; marks 512-bit block boundaries so the core knows when to start each compression.

Parameters:
- MSG_W, 1024, padded message width in bits.
- WORD_W, 32, output word width.
- BLOCK_WORDS, 16, words per 512-bit SHA block.
- EXP_LEN, 640, required message-length field value in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  1-cycle strobe: capture msg_in; honoured only in IDLE.
- msg_in  input  1024  padded message, bit 1023 = first header bit.
- flush  input  1  synchronous abort back to IDLE, any state.
- busy  output  1  high in CHECK and STREAM.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  32  current word.
- out_word_idx  output  4  word index within the current block, 0..15.
- out_block_idx  output  1  0 = first 512-bit block, 1 = second.
- out_block_first  output  1  out_word_idx == 0.
- out_block_last  output  1  out_word_idx == 15.
- out_last  output  1  final word of the message (global index 31).
- done  output  1  1-cycle pulse after the last word transfers.
- pad_err  output  1  1-cycle pulse when the padding check fails.

Behaviour:
- Reset (async, rst high):
  - State = IDLE; shift register and word counter = 0.
  - All outputs = 0.
- Message layout checked in CHECK:
  - Header occupies [1023:384].
  - Bit 383 must be 1 (separator).
  - Bits [382:64] must all be 0.
  - Bits [63:0] must equal EXP_LEN.
- IDLE:
  - load=1 → capture msg_in into a 1024-bit shift register, clear the 5-bit word counter, go to CHECK.
- CHECK (exactly 1 cycle):
  - out_valid stays 0.
  - Check passes → STREAM.
  - Check fails → pad_err=1 for this cycle, then IDLE. No words are emitted.
- STREAM:
  - out_valid=1.
  - out_data = shift register [1023:992].
  - out_word_idx = counter[3:0]; out_block_idx = counter[4].
  - On out_valid & out_ready: shift the register left by 32 and increment the counter.
  - Transfer when counter == 31 → next cycle state = IDLE, out_valid=0, done=1 for one cycle.
- Handshake rules:
  - When out_ready=0, out_data and all index/flag outputs hold stable.
  - out_valid never deasserts without a transfer, except on flush or rst.
- Latency:
  - load at cycle N → CHECK at N+1 → first out_valid at N+2.
  - Minimum total with out_ready held high: 34 cycles from load to done.
- load while busy: ignored; the in-flight message is unaffected.
- load in the same cycle as done: done is registered, so the state is already IDLE and the load is accepted.
- flush:
  - Next cycle state = IDLE and out_valid=0.
  - No done and no pad_err.
  - flush and load together in IDLE: flush wins; the message is not captured.
- rst mid-stream: immediate return to the reset state; a partial message is never resumed.
- Widths: counter wraps only through the return to IDLE and never reaches 32 in STREAM. The length compare is a 64-bit equality.

Decomposition:
- Shared package sha_pkg holds:
  - Constants MSG_W, WORD_W, BLOCK_WORDS, EXP_LEN, SEP_BIT=383, LEN_LSB=0, LEN_MSB=63.
  - Reader state enum {IDLE, CHECK, STREAM}.
- One natural sub-module, pad_checker: purely combinational; takes the 1024-bit message and returns pad_ok. It is reusable by the padder's own self-check.

Test Plan:
- Correct message with ready held high:
  - Stimulus: header 0x01..0x50 in bytes, bit383=1, len=640, load, out_ready=1.
  - Required response:
    - 32 consecutive words; word0 = 0x01020304; word20 = 0x80000000; word31 = 0x00000280.
    - out_block_first on words 0 and 16; out_block_last on words 15 and 31; out_last only on word 31.
    - done pulses at cycle load+34.
- Backpressure:
  - Stimulus: same message; out_ready toggles 1,0,0,1,…
  - Required response: each word is held stable while ready=0; no words are lost or duplicated; the sequence is identical to the first test.
- Bad separator:
  - Stimulus: bit383=0.
  - Required response: pad_err pulses at load+1; out_valid is never asserted; busy=0 at load+2.
- Bad length:
  - Stimulus: len=512, or any nonzero bit in [382:64].
  - Required response: pad_err pulse; no output words.
- load ignored while busy, then flush:
  - Stimulus: second load (different data) at word 5, then flush at word 10.
  - Required response: words 0-9 come from the first message; out_valid=0 the cycle after flush; no done. A fresh load then streams the new message from word 0.
- Asynchronous reset mid-stream:
  - Stimulus: rst asserted between clock edges at word 12.
  - Required response: all outputs drop to 0 without waiting for a clock edge; after release the block is in IDLE and accepts a load.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared constants and reader state encoding for the SHA-256 padded-message path.
package sha_pkg;

  localparam int MSG_W       = 1024;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int MSG_WORDS   = MSG_W / WORD_W;
  localparam int SEP_BIT     = 383;
  localparam int LEN_LSB     = 0;
  localparam int LEN_MSB     = 63;
  localparam logic [63:0] EXP_LEN = 64'd640;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STREAM
  } rd_state_t;

endpackage

// File: rtl/padded_msg_reader_if.sv
// Word stream from the padded-message reader to the SHA-256 core.
interface padded_msg_reader_if;
  import sha_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [3:0]        out_word_idx;
  logic              out_block_idx;
  logic              out_block_first;
  logic              out_block_last;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_word_idx, out_block_idx,
           out_block_first, out_block_last, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_word_idx, out_block_idx,
           out_block_first, out_block_last, out_last,
    output out_ready
  );
endinterface

// File: rtl/padded_msg_reader_pad_checker.sv
// Combinational well-formedness check of a padded 80-byte header message.
module pad_checker
  import sha_pkg::*;
(
  input  logic [MSG_W-1:0] msg,
  output logic             pad_ok
);

  assign pad_ok = msg[SEP_BIT]
               && (msg[SEP_BIT-1:LEN_MSB+1] == '0)
               && (msg[LEN_MSB:LEN_LSB] == EXP_LEN);

endmodule

// File: rtl/padded_msg_reader.sv
// Captures a padded message, validates its padding, and streams it MSB-first
// as 32-bit words with block-boundary markers.
//   state  | meaning
//   IDLE   | waiting for load
//   CHECK  | one cycle: padding check on the captured message
//   STREAM | presenting words, advancing on each handshake
module padded_msg_reader
  import sha_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MSG_W-1:0]    msg_in,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic                pad_err,
  padded_msg_reader_if.master out
);

  rd_state_t        state, state_nxt;
  logic [MSG_W-1:0] sh_reg;
  logic [4:0]       cnt;
  logic             pad_ok;
  logic             xfer;
  logic             last_word;
  logic             stream_on;

  pad_checker u_pad_checker (
    .msg    (sh_reg),
    .pad_ok (pad_ok)
  );

  assign xfer      = (state == STREAM) && out.out_ready;
  assign last_word = (cnt == 5'(MSG_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    pad_err   = 1'b0;
    stream_on = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (pad_ok) begin
          state_nxt = STREAM;
        end else begin
          state_nxt = IDLE;
          pad_err   = !flush;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        stream_on = 1'b1;
        if (xfer && last_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Shifting moves the next word into the top slice, so out_data is a fixed tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= xfer && last_word && !flush;
      if (state == IDLE && load && !flush) begin
        sh_reg <= msg_in;
        cnt    <= '0;
      end else if (xfer && !flush) begin
        sh_reg <= sh_reg << WORD_W;
        cnt    <= cnt + 5'd1;
      end
    end
  end

  assign out.out_valid       = stream_on;
  assign out.out_data        = stream_on ? sh_reg[MSG_W-1 -: WORD_W] : '0;
  assign out.out_word_idx    = stream_on ? cnt[3:0] : 4'd0;
  assign out.out_block_idx   = stream_on && cnt[4];
  assign out.out_block_first = stream_on && (cnt[3:0] == 4'd0);
  assign out.out_block_last  = stream_on && (cnt[3:0] == 4'(BLOCK_WORDS - 1));
  assign out.out_last        = stream_on && last_word;

endmodule

// File: tb/tb_padded_msg_reader.sv
// Scoreboard bench for padded_msg_reader: random and directed messages against a
// word-list reference model built from the message layout.
module tb_padded_msg_reader;
  import sha_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  widx;
    logic        bidx;
    logic        first;
    logic        blast;
    logic        last;
  } word_t;

  logic             clk;
  logic             rst;
  logic             load;
  logic [MSG_W-1:0] msg_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic             pad_err;

  padded_msg_reader_if bus ();

  padded_msg_reader dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .msg_in  (msg_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .pad_err (pad_err),
    .out     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  word_t       sbq[$];
  logic [31:0] rx_data[$];
  bit          stall_pend = 0;
  word_t       held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic word_t cur_word();
    word_t w;
    w.data  = bus.out_data;
    w.widx  = bus.out_word_idx;
    w.bidx  = bus.out_block_idx;
    w.first = bus.out_block_first;
    w.blast = bus.out_block_last;
    w.last  = bus.out_last;
    return w;
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks stalled words hold.
  always @(negedge clk) begin
    word_t c, e;
    if (rst) begin
      stall_pend = 0;
    end else begin
      c = cur_word();
      if (done) done_cnt++;
      if (stall_pend) begin
        chk("hold_stable", {23'd0, bus.out_valid, c}, {23'd0, 1'b1, held});
        stall_pend = 0;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word: got %h with no word expected", c);
          end else begin
            e = sbq.pop_front();
            chk("word", 64'(c), 64'(e));
          end
          rx_data.push_back(bus.out_data);
        end else if (!flush) begin
          stall_pend = 1;
          held       = c;
        end
      end
    end
  end

  // Reference: the message is 32 big-endian words; block = index/16, position = index%16.
  task automatic push_expected(input logic [MSG_W-1:0] m);
    word_t w;
    for (int i = 0; i < 32; i++) begin
      w.data  = m[MSG_W-1-32*i -: 32];
      w.widx  = 4'(i % 16);
      w.bidx  = (i >= 16);
      w.first = (i % 16 == 0);
      w.blast = (i % 16 == 15);
      w.last  = (i == 31);
      sbq.push_back(w);
    end
  endtask

  function automatic logic [MSG_W-1:0] make_msg(input logic [639:0] hdr, input bit sep,
                                                input logic [318:0] fill, input logic [63:0] len);
    return {hdr, sep, fill, len};
  endfunction

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int i = 0; i < 20; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  function automatic bit ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_msg(input logic [MSG_W-1:0] m, input bit good, input int mode, input bit chk_lat);
    int base, c, dbase;
    base  = rx_data.size();
    dbase = done_cnt;
    if (good) push_expected(m);
    @(posedge clk); #1;
    load = 1'b1; msg_in = m; bus.out_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    chk("pad_err_at_check", 64'(pad_err), 64'(!good));
    @(posedge clk); #1;
    bus.out_ready = ready_for(mode, 2);
    if (!good) begin
      @(negedge clk);
      chk("bad_idle", {61'd0, busy, bus.out_valid, pad_err}, 64'd0);
      repeat (3) @(posedge clk);
      chk("bad_no_words", 64'(rx_data.size() - base), 64'd0);
      return;
    end
    c = 2;
    while (c < 400) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      c++;
      bus.out_ready = ready_for(mode, c);
    end
    chk("done_seen", 64'(c < 400), 64'd1);
    if (chk_lat) chk("done_latency", 64'(c), 64'd34);
    chk("word_count", 64'(rx_data.size() - base), 64'd32);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    @(negedge clk);
    chk("done_pulse_1cyc", {63'd0, done}, 64'd0);
    chk("done_count", 64'(done_cnt - dbase), 64'd1);
    sbq.delete();
  endtask

  task automatic wait_rx(input int target, input string name);
    int k;
    k = 0;
    while (rx_data.size() < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 64'(rx_data.size() >= target), 64'd1);
  endtask

  initial begin
    logic [639:0]     hdr;
    logic [MSG_W-1:0] m, mb;
    int               base, kind, dbase;

    rst = 1'b1; load = 1'b0; flush = 1'b0; msg_in = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {20'd0, bus.out_valid, bus.out_data, bus.out_word_idx, bus.out_block_idx,
        bus.out_block_first, bus.out_block_last, bus.out_last, busy, done, pad_err}, 64'd0);
    rst = 1'b0;

    // Directed message: header bytes 0x01..0x50.
    for (int k = 0; k < 80; k++) hdr[639-8*k -: 8] = 8'(k + 1);
    m = make_msg(hdr, 1'b1, '0, 64'd640);
    base = rx_data.size();
    run_msg(m, 1'b1, 0, 1'b1);
    chk("word0",  64'(rx_data[base+0]),  64'h01020304);
    chk("word20", 64'(rx_data[base+20]), 64'h80000000);
    chk("word31", 64'(rx_data[base+31]), 64'h00000280);

    // Backpressure 1,0,0,1 on the same message.
    run_msg(m, 1'b1, 1, 1'b0);

    // Padding faults.
    run_msg(make_msg(hdr, 1'b0, '0, 64'd640), 1'b0, 0, 1'b0);
    run_msg(make_msg(hdr, 1'b1, '0, 64'd512), 1'b0, 0, 1'b0);
    run_msg(make_msg(hdr, 1'b1, 319'd1 << 100, 64'd640), 1'b0, 0, 1'b0);

    // Random mix of good and bad messages with random backpressure.
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_msg(make_msg(rand_hdr(), 1'b1, '0, 64'd640), 1'b1, 2, 1'b0);
        1: run_msg(make_msg(rand_hdr(), 1'b0, '0, 64'd640), 1'b0, 2, 1'b0);
        2: run_msg(make_msg(rand_hdr(), 1'b1, 319'd1 << $urandom_range(0, 318), 64'd640), 1'b0, 2, 1'b0);
        default: run_msg(make_msg(rand_hdr(), 1'b1, '0, {32'd0, $urandom} ^ 64'd640 | 64'h1000), 1'b0, 2, 1'b0);
      endcase
    end

    // Load while busy is ignored; flush at word 10 aborts without done.
    m  = make_msg(rand_hdr(), 1'b1, '0, 64'd640);
    mb = make_msg(rand_hdr(), 1'b1, '0, 64'd640);
    base  = rx_data.size();
    dbase = done_cnt;
    push_expected(m);
    @(posedge clk); #1;
    load = 1'b1; msg_in = m; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    wait_rx(base + 5, "reach_word5");
    load = 1'b1; msg_in = mb;
    @(posedge clk); #1;
    load = 1'b0;
    wait_rx(base + 10, "reach_word10");
    flush = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_idle", {62'd0, bus.out_valid, busy}, 64'd0);
    chk("flush_words", 64'(rx_data.size() - base), 64'd10);
    chk("flush_remaining", 64'(sbq.size()), 64'd22);
    sbq.delete();
    repeat (40) @(posedge clk);
    chk("flush_no_done", 64'(done_cnt - dbase), 64'd0);
    run_msg(mb, 1'b1, 2, 1'b0);

    // Async reset at word 12.
    m = make_msg(rand_hdr(), 1'b1, '0, 64'd640);
    base = rx_data.size();
    push_expected(m);
    @(posedge clk); #1;
    load = 1'b1; msg_in = m; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    wait_rx(base + 12, "reach_word12");
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {20'd0, bus.out_valid, bus.out_data, bus.out_word_idx, bus.out_block_idx,
        bus.out_block_first, bus.out_block_last, bus.out_last, busy, done, pad_err}, 64'd0);
    sbq.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {62'd0, busy, bus.out_valid}, 64'd0);
    run_msg(make_msg(rand_hdr(), 1'b1, '0, 64'd640), 1'b1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
